// File: rtl/mux_scan_ctrl.sv
// Scan sequencer wrapped around a 16:1 bit mux: steps the select through
// channels 0..LAST_CH, samples the mux output, and publishes one word per frame.
module mux_scan_ctrl #(
  parameter int SETTLE  = 1,
  parameter int LAST_CH = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic [15:0] data_out,
  output logic        valid,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);
  localparam logic [3:0]  LAST_SEL   = 4'(LAST_CH);
  localparam logic [15:0] CH_MASK    = 16'((1 << (LAST_CH + 1)) - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] shadow;
  logic [15:0] merged;

  // Shadow word with the bit being sampled on this edge already folded in.
  always_comb begin
    merged      = shadow;
    merged[sel] = y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 4'd0;
      cnt      <= 4'd0;
      shadow   <= 16'd0;
      data_out <= 16'd0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          sel  <= 4'd0;
          busy <= 1'b0;
          if (start && !stop) begin
            state  <= SCAN;
            busy   <= 1'b1;
            cnt    <= 4'd0;
            shadow <= 16'd0;
          end
        end
        SCAN: begin
          if (stop) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sel    <= 4'd0;
            cnt    <= 4'd0;
            shadow <= 16'd0;
          end else if (cnt < SETTLE_CNT) begin
            cnt <= cnt + 4'd1;
          end else begin
            cnt <= 4'd0;
            if (sel != LAST_SEL) begin
              shadow <= merged;
              sel    <= sel + 4'd1;
            end else begin
              // End of frame: publish, and either roll straight into the next frame or stop.
              data_out <= merged & CH_MASK;
              valid    <= 1'b1;
              sel      <= 4'd0;
              shadow   <= 16'd0;
              if (!cont) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer that sits directly around the 16:1 bit mux. It drives the mux select and consumes the mux output, scanning channels 0..LAST_CH. It waits SETTLE cycles per channel, then samples the mux output into a shadow register. At the end of each frame it presents a 16-bit parallel word with a one-cycle valid strobe. Used to read back banks of switches and status lines through a single 16:1 mux.

Parameters:
SETTLE, 1, extra wait cycles per channel before sampling; legal range 0..15; each channel occupies SETTLE+1 cycles.
LAST_CH, 15, highest channel scanned; legal range 0..15; channels above LAST_CH are never selected and read as 0.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  level; sampled in IDLE only, begins a frame
stop  in  1  level; aborts a frame in progress
cont  in  1  continuous mode; sampled at each end-of-frame edge
y_in  in  1  mux output Y
sel  out  4  mux select S; registered
data_out  out  16  last complete frame; bit k = y_in sampled while sel==k
valid  out  1  one-cycle pulse, data_out updated this cycle
busy  out  1  high while in SCAN

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-frame:
  - state=IDLE, sel=0, cnt=0, shadow=0, data_out=0, valid=0, busy=0.
  - Reset overrides start and stop.
- Internal registers: 2-state FSM {IDLE, SCAN}; 4-bit settle counter cnt; 16-bit shadow.
- IDLE:
  - busy=0, sel=0.
  - start=1 and stop=0 at edge E0: state<=SCAN, sel<=0, cnt<=0, shadow<=0.
  - start=1 and stop=1 together: stop wins, remain IDLE.
- SCAN, busy=1. Priority at each edge:
  1. stop=1: state<=IDLE, sel<=0, shadow discarded, data_out unchanged, no valid.
  2. cnt<SETTLE: cnt<=cnt+1, sel held.
  3. cnt==SETTLE (sample edge): shadow[sel]<=y_in, cnt<=0.
     - sel<LAST_CH: sel<=sel+1.
     - sel==LAST_CH (end of frame): data_out<=shadow with the new bit merged, bits above LAST_CH forced 0; valid<=1; sel<=0; then state<=SCAN if cont=1, else IDLE.
- Sample edge for channel k (0-based): E0 + (k+1)*(SETTLE+1).
- Frame length is F = (LAST_CH+1)*(SETTLE+1) cycles. valid is high for exactly the one cycle after edge E0+F.
- In continuous mode frames are back-to-back: next valid at E0+2F. There are no idle cycles between frames.
- valid is 0 in every other cycle. data_out changes only on valid cycles or on reset.
- start while in SCAN is ignored. Changing cont mid-frame has no effect until the end-of-frame edge.
- sel never exceeds LAST_CH; sel wraps LAST_CH->0 only at end of frame.
- The mux is combinational. y_in is assumed stable by the sample edge when SETTLE>=0; no input synchronizer is included.
- Expected size: roughly 120-200 lines RTL.

Test Plan:
- Single frame, SETTLE=1, LAST_CH=15: bench mux model with D=16'hA5C3, pulse start one cycle -> sel steps 0..15, each held 2 cycles; valid high exactly one cycle, 32 cycles after start edge; data_out=16'hA5C3; busy then 0, sel=0.
- Continuous, cont=1: D=16'h0001 for frame 1, switch to 16'h8000 during frame 2 before channel 0's sample -> valid pulses 32 cycles apart; data_out 16'h0001 then 16'h8000; busy stays 1.
- Partial scan, SETTLE=0, LAST_CH=7: D=16'hFFFF -> sel never exceeds 7; valid 8 cycles after start; data_out=16'h00FF.
- Abort: stop=1 while sel==5 after a prior frame left data_out=16'hA5C3 -> next cycle busy=0, sel=0; no valid; data_out stays 16'hA5C3. start=1 with stop=1 in IDLE -> stays IDLE.
- Reset mid-frame: rst=1 at sel==9 -> next cycle sel=0, data_out=0, valid=0, busy=0; a subsequent start runs a full correct frame.
- start re-asserted while busy -> ignored; frame timing and data_out are identical to the single-frame case.
